vga_scan_sched: RTL and testbench
=================================

# vga_scan_sched

Scan-timing and pattern-scheduling controller for the VGA test-pattern path. It generates 640x480@60 raster counters and sync pulses, and drives `x`/`y` into the combinational bar/region pattern generator. It registers the returned 30-bit colour with blanking applied, and selects which pattern index is shown, changing it only at frame boundaries. Patterns advance automatically every N frames or on a manual step request.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `FRAMES_PER_PAT`, 60, frames per pattern in auto mode (>=1)
- `NUM_PATS`, 8, pattern count, 1..8
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate enable; all raster state advances only when high
- `step`  in  1  manual advance request, level; rising edge detected internally
- `hold`  in  1  1 = suspend auto-advance
- `pat_rgb`  in  30  colour from pattern generator for current `x`,`y` ({R,G,B}, 10b each)
- `x`  out  10  horizontal counter, 0..H_total-1
- `y`  out  10  vertical counter, 0..V_total-1
- `pat_sel`  out  3  active pattern index, 0..NUM_PATS-1
- `frame_start`  out  1  one-clk pulse at raster wrap to (0,0)
- `hsync`, `vsync`  out  1  active-low syncs, aligned to `rgb_out`
- `blank_n`  out  1  1 in active area, aligned to `rgb_out`
- `rgb_out`  out  30  registered colour, zero when blanked

## Operation
- H_total = 800, V_total = 525 with defaults. `x` increments on each `pix_en`. At H_total-1 it wraps to 0 and `y` increments. `y` wraps after V_total-1.
- Active area: `x`<H_ACTIVE and `y`<V_ACTIVE.
- Syncs: hsync low for H_ACTIVE+H_FP <= `x` < H_ACTIVE+H_FP+H_SYNC. vsync low for the analogous `y` range.
- Output stage, updated on `pix_en`: if active, `rgb_out` <= `pat_rgb`; otherwise `rgb_out` <= 0. `blank_n`, `hsync` and `vsync` are registered from the same `x`,`y`.
- Scheduler:
  - `frame_cnt` runs 0..FRAMES_PER_PAT-1 and increments at each `frame_start`.
  - At the boundary where `frame_cnt`=FRAMES_PER_PAT-1 and `hold`=0, `pat_sel` advances.
  - `pat_sel` advance is +1 mod NUM_PATS.
- Step:
  - A rising edge of `step` (compared against the previous clk sample, independent of `pix_en`) sets `step_pend`.
  - At the next `frame_start`, `step_pend` advances `pat_sel`, clears `frame_cnt` to 0 and clears itself.
  - Additional edges while pending are absorbed (one advance only).
- Simultaneous step-pending and auto-advance at the same boundary: advance exactly once, `frame_cnt` <= 0.
- `hold`=1: `frame_cnt` freezes at its value; step still applies.
- `pat_sel` never changes except in the `frame_start` cycle. No mid-frame tearing.

## Timing
- Reset values:
  - `x`=`y`=0, `frame_cnt`=0, `pat_sel`=0, `step_pend`=0.
  - `frame_start`=0, `hsync`=`vsync`=1, `blank_n`=0, `rgb_out`=0.
- `x`/`y` are registers. `pat_rgb` is sampled in the same `pix_en` cycle, so `rgb_out`/syncs/`blank_n` lag `x`/`y` by exactly one `pix_en` period.
- `frame_start` is high for the single clk in which the counters wrap from (H_total-1, V_total-1) to (0,0). The new `pat_sel` is visible the following clk.
- `pix_en`=0: all registers hold, including outputs. Step edge detection still runs.
- Reset asserted mid-frame: everything returns to reset values on the next clk. A pending step is discarded.
- Frame period: H_total*V_total `pix_en` cycles (420000 with defaults).

## Configuration
- `VGA_SCHED_BORDER_EN` defined: within the active area, pixels with `x`=0, `x`=H_ACTIVE-1, `y`=0 or `y`=V_ACTIVE-1 output `rgb_out`=30'h3FFFFFFF, overriding `pat_rgb`. Used for monitor alignment.
- Not defined: `rgb_out` is always `pat_rgb` in the active area. No border logic is synthesised.

## Test plan
- Reset: assert `reset` 3 clks with `pix_en`=1 -> all outputs at reset values; after release, `x` reads 1 after the first `pix_en`.
- Line/frame timing, `pix_en` every clk:
  - `hsync` low for 96 consecutive pixels starting one pixel after `x`=656.
  - `vsync` low for 2 lines starting one pixel after (`y`=490, `x`=0).
  - `frame_start` every 420000 clks.
- Blanking: `pat_rgb`=30'h3FFFFFFF constant -> `rgb_out`=0 whenever `blank_n`=0, and =30'h3FFFFFFF otherwise, with one-pixel lag.
- Auto-advance, FRAMES_PER_PAT=2, NUM_PATS=3 -> `pat_sel` sequence 0,1,2,0 changing every 2nd `frame_start`. With `hold`=1 it stays constant.
- Step mid-frame, including 3 step pulses in one frame -> single `pat_sel` increment at the next `frame_start`, `frame_cnt`=0. Step coinciding with an auto boundary -> +1 only.
- `pix_en` toggled 1-of-2 -> counters and outputs advance at half rate and hold in gap cycles. With `VGA_SCHED_BORDER_EN`, pixel (0,0) and (639,479) = 30'h3FFFFFFF.

Source files
------------

// File: rtl/vga_scan_sched.sv
// 640x480@60 raster timing, registered pattern output stage and frame-aligned pattern scheduler.
// Optional build macro VGA_SCHED_BORDER_EN forces a full-white one-pixel border on the active area.
module vga_scan_sched #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter int unsigned FRAMES_PER_PAT = 60,
  parameter int unsigned NUM_PATS       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        step,
  input  logic        hold,
  input  logic [29:0] pat_rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  pat_sel,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [29:0] rgb_out
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FcW    = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

  localparam logic [9:0]     XLast      = 10'(HTotal - 1);
  localparam logic [9:0]     YLast      = 10'(VTotal - 1);
  localparam logic [9:0]     XActive    = 10'(H_ACTIVE);
  localparam logic [9:0]     YActive    = 10'(V_ACTIVE);
  localparam logic [9:0]     HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]     HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]     VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]     VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FcW-1:0] FcLast     = FcW'(FRAMES_PER_PAT - 1);
  localparam logic [2:0]     PatLast    = 3'(NUM_PATS - 1);

  logic           x_last, y_last;
  logic           active, hs_act, vs_act;
  logic           step_q, step_rise, step_pend;
  logic           advance;
  logic [FcW-1:0] frame_cnt;
  logic [2:0]     pat_next;
  logic [29:0]    pix_rgb;

  assign x_last    = (x == XLast);
  assign y_last    = (y == YLast);
  assign active    = (x < XActive) && (y < YActive);
  assign hs_act    = (x >= HSyncStart) && (x < HSyncEnd);
  assign vs_act    = (y >= VSyncStart) && (y < VSyncEnd);
  assign step_rise = step & ~step_q;

  // Combinational so it marks exactly the clk whose edge wraps the raster, even with pix_en gaps.
  assign frame_start = pix_en & x_last & y_last & ~reset;

  // A pending step and an auto boundary coinciding still produce one advance.
  assign advance  = step_pend | ((frame_cnt == FcLast) & ~hold);
  assign pat_next = (pat_sel == PatLast) ? 3'd0 : pat_sel + 3'd1;

`ifdef VGA_SCHED_BORDER_EN
  logic on_border;
  assign on_border = (x == 10'd0) || (x == XActive - 10'd1) ||
                     (y == 10'd0) || (y == YActive - 10'd1);
  assign pix_rgb   = on_border ? 30'h3FFFFFFF : pat_rgb;
`else
  assign pix_rgb   = pat_rgb;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
      pat_sel   <= '0;
      step_pend <= 1'b0;
      step_q    <= step;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank_n   <= 1'b0;
      rgb_out   <= '0;
    end else begin
      step_q <= step;

      if (frame_start) begin
        // An edge landing on the boundary clk itself waits for the next frame.
        step_pend <= step_rise;
        if (advance) begin
          pat_sel   <= pat_next;
          frame_cnt <= '0;
        end else if (!hold) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else if (step_rise) begin
        step_pend <= 1'b1;
      end

      if (pix_en) begin
        x <= x_last ? 10'd0 : x + 10'd1;
        if (x_last) begin
          y <= y_last ? 10'd0 : y + 10'd1;
        end
        blank_n <= active;
        hsync   <= ~hs_act;
        vsync   <= ~vs_act;
        rgb_out <= active ? pix_rgb : 30'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_sched.sv
// Bench for vga_scan_sched on a shrunken 15x10 raster: directed timing/scheduler checks plus
// randomized stimulus compared every clk against a linear-pixel-position reference model.
module tb_vga_scan_sched;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;  // 15
  localparam int VT = VA + VFP + VS + VBP;  // 10
  localparam int FL = HT * VT;              // 150 pixels per frame
  localparam int FPP = 2, NP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, pix_en = 1'b1, step = 1'b0, hold = 1'b0;
  logic [29:0] pat_rgb = '1;
  logic [9:0]  x, y;
  logic [2:0]  pat_sel;
  logic        frame_start, hsync, vsync, blank_n;
  logic [29:0] rgb_out;

  vga_scan_sched #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FRAMES_PER_PAT(FPP), .NUM_PATS(NP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .step(step), .hold(hold), .pat_rgb(pat_rgb),
    .x(x), .y(y), .pat_sel(pat_sel), .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, cyc = 0;
  // Reference state: linear pixel position within the frame plus scheduler bookkeeping.
  int m_pos = 0, m_fcnt = 0, m_pat = 0;
  logic m_pend = 1'b0, m_prev = 1'b0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_bn = 1'b0;
  logic [29:0] e_rgb = '0;
  logic fs_seen = 1'b0;
  int last_fs_cyc = -1, fs_period = 0;
  logic measure_en = 1'b0;
  int hs_run = 0, hs_last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycle(input logic r, input logic pe, input logic st, input logic hd,
                       input logic [29:0] rgb);
    logic exp_fs, rise, act;
    int px, py;
    @(negedge clk);
    reset = r; pix_en = pe; step = st; hold = hd; pat_rgb = rgb;
    #1;
    exp_fs = !r && pe && (m_pos == FL - 1);
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    fs_seen = (frame_start === 1'b1);
    if (fs_seen) begin
      if (last_fs_cyc >= 0) fs_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      m_pos = 0; m_fcnt = 0; m_pat = 0; m_pend = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = '0;
    end else begin
      rise = st && !m_prev;
      if (exp_fs) begin
        if (m_pend || (m_fcnt == FPP - 1 && !hd)) begin
          m_pat = (m_pat + 1) % NP;
          m_fcnt = 0;
        end else if (!hd) begin
          m_fcnt++;
        end
        m_pend = rise;
      end else if (rise) begin
        m_pend = 1'b1;
      end
      if (pe) begin
        px = m_pos % HT;
        py = m_pos / HT;
        act = (px < HA) && (py < VA);
        e_bn = act;
        e_hs = !(px >= HA + HFP && px < HA + HFP + HS);
        e_vs = !(py >= VA + VFP && py < VA + VFP + VS);
        e_rgb = act ? rgb : 30'd0;
`ifdef VGA_SCHED_BORDER_EN
        if (act && (px == 0 || px == HA - 1 || py == 0 || py == VA - 1)) e_rgb = '1;
`endif
        m_pos = (m_pos + 1) % FL;
      end
    end
    m_prev = st;
    #1;
    chk("x", 32'(x), 32'(m_pos % HT));
    chk("y", 32'(y), 32'(m_pos / HT));
    chk("pat_sel", 32'(pat_sel), 32'(m_pat));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("blank_n", 32'(blank_n), 32'(e_bn));
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    if (measure_en) begin
      if (hsync === 1'b0) hs_run++;
      else if (hs_run > 0) begin
        hs_last_run = hs_run;
        hs_run = 0;
      end
    end
  endtask

  task automatic run_frames(input int n, input logic hd);
    int seen, guard;
    seen = 0;
    guard = 0;
    while (seen < n && guard < n * 2 * FL) begin
      cycle(1'b0, 1'b1, 1'b0, hd, '1);
      if (fs_seen) seen++;
      guard++;
    end
    if (seen < n) chk("frame_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    logic r, pe, st, hd;
    // Reset held 3 clks with pix_en high.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, '1);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_pat", 32'(pat_sel), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_blank_n", 32'(blank_n), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '1);
    chk("first_x", 32'(x), 32'd1);

    // Auto advance every 2nd frame: 0,1,2,0; also frame period and hsync width.
    measure_en = 1'b1;
    run_frames(2, 1'b0);
    chk("auto_pat_1", 32'(pat_sel), 32'd1);
    run_frames(2, 1'b0);
    chk("auto_pat_2", 32'(pat_sel), 32'd2);
    run_frames(2, 1'b0);
    chk("auto_pat_0", 32'(pat_sel), 32'd0);
    measure_en = 1'b0;
    chk("frame_period", 32'(fs_period), 32'd150);
    chk("hsync_width", 32'(hs_last_run), 32'd3);

    // Hold freezes auto-advance.
    run_frames(4, 1'b1);
    chk("hold_pat", 32'(pat_sel), 32'd0);

    // Three step pulses within one frame give a single advance.
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, '1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, '1);
    end
    chk("step_no_tear", 32'(pat_sel), 32'd0);
    run_frames(1, 1'b1);
    chk("step_once", 32'(pat_sel), 32'd1);

    // Step pending on an auto boundary: +1 only, and frame count restarts.
    run_frames(1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '1);
    run_frames(1, 1'b0);
    chk("step_auto_once", 32'(pat_sel), 32'd2);
    run_frames(1, 1'b0);
    chk("cnt_restart", 32'(pat_sel), 32'd2);
    run_frames(1, 1'b0);
    chk("auto_after_step", 32'(pat_sel), 32'd0);

    // Half-rate pix_en: 20 clks advance x by 10.
    for (int i = 0; i < 20; i++) cycle(1'b0, (i % 2) == 0, 1'b0, 1'b0, '1);
    chk("half_rate_x", 32'(x), 32'd10);

    // Randomized phase against the reference model.
    st = 1'b0;
    hd = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      r  = ($urandom_range(0, 2999) == 0);
      pe = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) st = ~st;
      if ($urandom_range(0, 499) == 0) hd = ~hd;
      cycle(r, pe, st, hd, 30'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
